// File: rtl/tpsram_pkg.sv
// Shared definitions for the tpsram two-port RAM.
//   init_state_e : zero-fill FSM state (INIT while clearing, READY after)
//   MAX_LAT      : largest supported read latency
//   BYTE_W       : width of one byte-enable lane
package tpsram_pkg;

    localparam int MAX_LAT = 4;
    localparam int BYTE_W  = 8;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

endpackage

// File: rtl/tpsram_rdpipe.sv
// Read-result delay line: LAT stages of valid + data.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (clears valids and data)
//   in_valid_i   : a read result enters the line this cycle
//   in_data_i    : data of that result
//   out_valid_o  : result leaves the line (LAT cycles after entry)
//   out_data_o   : data of the most recent result; holds while out_valid_o is low
module tpsram_rdpipe #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);

    logic [LAT-1:0] valid_q;
    logic [W-1:0]   data_q [LAT];

    // Each data stage only loads behind a valid bit, so the last stage keeps
    // the previous result when no new read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LAT-1];
    assign out_data_o  = data_q[LAT-1];

endmodule

// File: rtl/tpsram.sv
// 1R1W RAM with byte enables, configurable read latency, selectable
// same-address collision behaviour and a zero-fill after every reset.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_be : write port; wr_be bit i qualifies byte i
//   rd_en/rd_addr     : read request; accepted only once init_done is high
//   rd_valid/rd_data  : read result LAT cycles after acceptance; rd_data holds
//                       its last value when rd_valid is low
//   init_done         : high once all N words have been cleared
//   dbg_state_o       : current zero-fill FSM state
// Handshake: a request is taken whenever its enable is high in a cycle where
// init_done is high; there is no back-pressure and results arrive in order.
module tpsram
    import tpsram_pkg::*;
#(
    parameter int W           = 32,
    parameter int N           = 128,
    parameter int LAT         = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic [W/8-1:0]       wr_be,
    input  logic                 rd_en,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [W-1:0]         rd_data,
    output logic                 init_done,
    output init_state_e          dbg_state_o
);

    localparam int AW = $clog2(N);
    localparam int NB = W / BYTE_W;

    if ((W % BYTE_W) != 0 || LAT < 1 || LAT > MAX_LAT || N < 2) begin : g_bad_param
        $error("tpsram: W must be a multiple of 8, LAT in 1..4, N >= 2");
    end

    init_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [N];

    logic          wr_accept, rd_accept;
    logic          wr_in_range, rd_in_range;
    logic [W-1:0]  rd_word;

    // Zero-fill sequencer: one address per cycle, stops at N-1 even when N
    // is not a power of two.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            if (cnt_q == AW'(N - 1)) begin
                state_d = READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done   = (state_q == READY);
    assign dbg_state_o = state_q;

    // Addresses at or above N (possible when N is not a power of two) are
    // dropped on write and read back as zero.
    assign wr_in_range = int'(wr_addr) < N;
    assign rd_in_range = int'(rd_addr) < N;
    assign wr_accept   = wr_en && init_done;
    assign rd_accept   = rd_en && init_done;

    // Array has no reset; it is only cleared by the zero-fill.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_accept && wr_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // The word is captured at acceptance, so later writes never reach an
    // in-flight result. In write-first mode a colliding write is merged in
    // byte by byte before capture.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[rd_addr];
        end
        if (WRITE_FIRST != 0 && wr_accept && wr_addr == rd_addr) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    tpsram_rdpipe #(
        .W   (W),
        .LAT (LAT)
    ) u_rdpipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_accept),
        .in_data_i   (rd_word),
        .out_valid_o (rd_valid),
        .out_data_o  (rd_data)
    );

endmodule

// File: tb/tb_tpsram.sv
// Bench for tpsram: two instances share one stimulus stream.
//   u0: W=32 N=128 LAT=1 WRITE_FIRST=1
//   u1: W=32 N=100 LAT=3 WRITE_FIRST=0
module tb_tpsram;
  import tpsram_pkg::*;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [6:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;

  logic        a_rd_valid, b_rd_valid;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_init_done, b_init_done;
  init_state_e a_state, b_state;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  tpsram #(.W(32), .N(128), .LAT(1), .WRITE_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(a_rd_valid),
    .rd_data(a_rd_data), .init_done(a_init_done), .dbg_state_o(a_state)
  );

  tpsram #(.W(32), .N(100), .LAT(3), .WRITE_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .init_done(b_init_done), .dbg_state_o(b_state)
  );

  // ---------------- model ----------------
  int          m_n   [2] = '{128, 100};
  int          m_lat [2] = '{1, 3};
  int          m_wf  [2] = '{1, 0};
  logic [31:0] m_mem [2][128];
  int          m_left [2];
  ent_t        q0[$];
  ent_t        q1[$];
  int          cyc;
  logic        exp_valid [2];
  logic [31:0] exp_data  [2];
  logic        exp_init  [2];

  logic        s_valid [2];
  logic [31:0] s_data  [2];
  logic        s_init  [2];

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 128; i++) m_mem[g][i] = '0;
      m_left[g]    = m_n[g];
      exp_valid[g] = 1'b0;
      exp_data[g]  = '0;
      exp_init[g]  = 1'b0;
    end
    q0.delete();
    q1.delete();
    cyc = 0;
  endtask

  // One clock edge of the behavioural RAM: a zero-fill of N cycles, then
  // reads snapshot the word (merged with a colliding write when write-first)
  // and come out LAT cycles later; writes update enabled bytes.
  task automatic model_edge();
    ent_t        e;
    logic [31:0] d;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (m_left[g] > 0) begin
        m_left[g]--;
      end else begin
        if (rd_en) begin
          d = (int'(rd_addr) < m_n[g]) ? m_mem[g][rd_addr] : 32'h0;
          if (wr_en && wr_addr == rd_addr && m_wf[g] == 1) d = merge(d, wr_data, wr_be);
          e.due  = cyc + m_lat[g] - 1;
          e.data = d;
          if (g == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        if (wr_en && int'(wr_addr) < m_n[g]) begin
          m_mem[g][wr_addr] = merge(m_mem[g][wr_addr], wr_data, wr_be);
        end
      end
      exp_valid[g] = 1'b0;
      if (g == 0 && q0.size() > 0 && q0[0].due == cyc) begin
        exp_valid[g] = 1'b1;
        exp_data[g]  = q0[0].data;
        void'(q0.pop_front());
      end
      if (g == 1 && q1.size() > 0 && q1[0].due == cyc) begin
        exp_valid[g] = 1'b1;
        exp_data[g]  = q1[0].data;
        void'(q1.pop_front());
      end
      exp_init[g] = (m_left[g] == 0);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance one clock: update the model at the edge, compare all outputs at
  // the falling edge, then return 1ns later so the caller can drive inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    s_valid[0] = a_rd_valid;  s_data[0] = a_rd_data;  s_init[0] = a_init_done;
    s_valid[1] = b_rd_valid;  s_data[1] = b_rd_data;  s_init[1] = b_init_done;
    chk("u0 rd_valid",  32'(s_valid[0]), 32'(exp_valid[0]));
    chk("u0 rd_data",   s_data[0],       exp_data[0]);
    chk("u0 init_done", 32'(s_init[0]),  32'(exp_init[0]));
    chk("u0 state",     32'(a_state),    32'(exp_init[0]));
    chk("u1 rd_valid",  32'(s_valid[1]), 32'(exp_valid[1]));
    chk("u1 rd_data",   s_data[1],       exp_data[1]);
    chk("u1 init_done", 32'(s_init[1]),  32'(exp_init[1]));
    chk("u1 state",     32'(b_state),    32'(exp_init[1]));
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(int a, logic [31:0] d, logic [3:0] be);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = d; wr_be = be;
  endtask

  task automatic rd(int a);
    rd_en = 1'b1; rd_addr = 7'(a);
  endtask

  int cnt_v [2];
  int n_bad;
  int first_v;
  int last_v;
  int exp_i;

  initial begin
    model_reset();
    repeat (3) tick();

    // Zero-fill timing: u1 ready after 100 edges, u0 after 128.
    rst = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k == 99)  chk("u1 init_done at 99",  32'(s_init[1]), 32'd0);
      if (k == 100) chk("u1 init_done at 100", 32'(s_init[1]), 32'd1);
      if (k == 127) chk("u0 init_done at 127", 32'(s_init[0]), 32'd0);
      if (k == 128) chk("u0 init_done at 128", 32'(s_init[0]), 32'd1);
    end

    // Every address reads back zero.
    cnt_v[0] = 0; cnt_v[1] = 0; n_bad = 0;
    for (int a = 0; a < 132; a++) begin
      if (a < 128) rd(a);
      else         rd_en = 1'b0;
      tick();
      for (int g = 0; g < 2; g++) begin
        if (s_valid[g]) begin
          cnt_v[g]++;
          if (s_data[g] !== 32'h0) n_bad++;
        end
      end
    end
    chk("zero-fill reads u0", 32'(cnt_v[0]), 32'd128);
    chk("zero-fill reads u1", 32'(cnt_v[1]), 32'd128);
    chk("zero-fill nonzero words", 32'(n_bad), 32'd0);

    // Byte-enable merge, plus a write with no enables.
    wr(5, 32'hDEADBEEF, 4'b1111); tick();
    wr(5, 32'h000000AA, 4'b0001); tick();
    wr(5, 32'h55555555, 4'b0000); tick();
    wr_en = 1'b0;
    rd(5); tick(); rd_en = 1'b0;
    chk("be merge u0 valid", 32'(s_valid[0]), 32'd1);
    chk("be merge u0 data",  s_data[0], 32'hDEADBEAA);
    chk("be merge u1 early", 32'(s_valid[1]), 32'd0);
    tick();
    chk("be merge u1 early2", 32'(s_valid[1]), 32'd0);
    tick();
    chk("be merge u1 valid", 32'(s_valid[1]), 32'd1);
    chk("be merge u1 data",  s_data[1], 32'hDEADBEAA);

    // Same-address collision.
    wr(7, 32'h11111111, 4'b1111); tick();
    wr(7, 32'h22222222, 4'b0011); rd(7); tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("collision write-first", s_data[0], 32'h11112222);
    tick(); tick();
    chk("collision read-first valid", 32'(s_valid[1]), 32'd1);
    chk("collision read-first", s_data[1], 32'h11111111);
    rd(7); tick(); rd_en = 1'b0;
    chk("after collision u0", s_data[0], 32'h11112222);
    tick(); tick();
    chk("after collision u1", s_data[1], 32'h11112222);

    // A write after acceptance must not reach the in-flight result.
    rd(5); tick(); rd_en = 1'b0;
    wr(5, 32'h00000000, 4'b1111); tick();
    wr_en = 1'b0; tick();
    chk("in-flight untouched u1", s_data[1], 32'hDEADBEAA);

    // Back-to-back reads through the 3-cycle instance.
    for (int i = 0; i < 10; i++) begin
      wr(i, 32'hC0DE0000 | 32'(i), 4'b1111); tick();
    end
    wr_en = 1'b0;
    first_v = -1; last_v = -1; cnt_v[1] = 0; n_bad = 0; exp_i = 0;
    for (int j = 0; j < 15; j++) begin
      if (j < 10) rd(j);
      else        rd_en = 1'b0;
      tick();
      if (s_valid[1]) begin
        if (first_v < 0) first_v = j;
        last_v = j;
        cnt_v[1]++;
        if (s_data[1] !== (32'hC0DE0000 | 32'(exp_i))) n_bad++;
        exp_i++;
      end
    end
    chk("stream first valid tick", 32'(first_v), 32'd2);
    chk("stream valid count", 32'(cnt_v[1]), 32'd10);
    chk("stream contiguous span", 32'(last_v - first_v + 1), 32'd10);
    chk("stream data order", 32'(n_bad), 32'd0);

    // Mixed random traffic over a small address window.
    for (int i = 0; i < 200; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 7'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 7'($urandom_range(0, 15));
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (4) tick();

    // Make addresses 3 and 99 non-zero so the refill is visible.
    wr(3, 32'hA5A5A5A5, 4'b1111); tick();
    wr(99, 32'h12345678, 4'b1111); tick();
    wr_en = 1'b0;

    // Reset with a read in flight in u1.
    rd(3); tick(); rd_en = 1'b0;
    rst = 1'b1; model_reset();
    cnt_v[0] = 0; cnt_v[1] = 0;
    repeat (3) begin
      tick();
      if (s_valid[0]) cnt_v[0]++;
      if (s_valid[1]) cnt_v[1]++;
    end
    chk("in-flight dropped u1", 32'(cnt_v[1]), 32'd0);
    chk("in-flight dropped u0", 32'(cnt_v[0]), 32'd0);

    // Reset again mid-fill at counter 60, with traffic that must be ignored.
    rst = 1'b0;
    repeat (60) tick();
    rst = 1'b1; model_reset();
    tick(); tick();
    rst = 1'b0;
    wr(3, 32'hFFFFFFFF, 4'b1111); rd(3);
    cnt_v[0] = 0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k == 90) wr_en = 1'b0;
      if (k <= 128 && s_valid[0]) cnt_v[0]++;
      if (k == 127) chk("refill u0 init_done at 127", 32'(s_init[0]), 32'd0);
      if (k == 128) chk("refill u0 init_done at 128", 32'(s_init[0]), 32'd1);
    end
    rd_en = 1'b0;
    chk("no rd_valid during refill", 32'(cnt_v[0]), 32'd0);
    repeat (4) tick();

    rd(3); tick();
    chk("refill addr3 u0", s_data[0], 32'h0);
    rd(99); tick(); rd_en = 1'b0;
    chk("refill addr99 u0", s_data[0], 32'h0);
    tick();
    chk("refill addr3 u1", s_data[1], 32'h0);
    tick();
    chk("refill addr99 u1 valid", 32'(s_valid[1]), 32'd1);
    chk("refill addr99 u1", s_data[1], 32'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
